// File: rtl/cmp_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : cmp_frame_packer
// Description : Packs 4-bit registered comparator sample vectors (S11, S21,
//               PAD1, PAD0) into 80-bit frames for the GTH TX word path.
//               Frame layout:
//                 [79:72] sync byte
//                 [71:68] frame sequence count
//                 [67:64] channel mask latched at frame start
//                 [63:0]  payload, sample k / channel c at bit 4*k+c
//               A single output slot with a valid/ready handshake holds one
//               frame. When a frame completes while the slot is occupied and
//               not being drained, the frame is dropped and counted.
// Ports       : sample_clk   - sample clock, rising edge
//               sample_rst_n - asynchronous active-low reset
//               en           - 1 = capture/pack, 0 = idle, discard partial
//               ch_mask      - per-channel enable, latched at frame start
//               cmp_data     - one sample vector per clock
//               frame_data   - output frame
//               frame_valid  - frame_data holds an unconsumed frame
//               frame_ready  - consumer accept
//               frame_cnt    - completed frames, saturating
//               drop_cnt     - dropped frames, saturating
//               overflow     - sticky drop flag, cleared by reset or en=0
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_frame_packer #(
    parameter logic [7:0] SYNC_BYTE = 8'hBC,
    parameter int         SAMPLES   = 16,
    parameter int         CNT_W     = 16
) (
    input  logic             sample_clk,
    input  logic             sample_rst_n,
    input  logic             en,
    input  logic [3:0]       ch_mask,
    input  logic [3:0]       cmp_data,
    output logic [79:0]      frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    // The frame format fixes SAMPLES at 16 so the payload is 64 bits.
    localparam int                 c_IDX_W = $clog2(SAMPLES);
    localparam int                 c_PAY_W = 4 * SAMPLES;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(SAMPLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [3:0]           r_mask;
    logic [3:0]           r_seq;
    logic [c_PAY_W-1:0]   r_shift;
    logic                 r_pend_valid;
    logic [79:0]          r_pend_data;

    logic                 w_capture;
    logic                 w_complete;
    logic [3:0]           w_mask_eff;
    logic [3:0]           w_sample;
    logic                 w_load_ok;
    logic                 w_drop;

    // On the first sample of a frame the mask register is only being
    // loaded, so the live ch_mask is used for that sample.
    assign w_capture  = (r_state == S_FILL) && en;
    assign w_complete = w_capture && (r_idx == c_LAST);
    assign w_mask_eff = (r_idx == '0) ? ch_mask : r_mask;
    assign w_sample   = cmp_data & w_mask_eff;
    assign w_load_ok  = !frame_valid || frame_ready;
    assign w_drop     = r_pend_valid && !w_load_ok;

    // ------------------------------------------------------------------
    // Capture FSM. Samples shift in from the top, so after 16 captures
    // sample 0 sits in the lowest nibble. A completed frame is parked in
    // the pending register for one cycle before the output slot decision.
    // ------------------------------------------------------------------
    always_ff @(posedge sample_clk or negedge sample_rst_n) begin
        if (!sample_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_mask       <= '0;
            r_seq        <= '0;
            r_shift      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_FILL;
                    end
                    S_FILL: begin
                        r_shift <= {w_sample, r_shift[c_PAY_W-1:4]};
                        if (r_idx == '0) begin
                            r_mask <= ch_mask;
                        end
                        if (w_complete) begin
                            r_idx        <= '0;
                            r_pend_valid <= 1'b1;
                            r_pend_data  <= {SYNC_BYTE, r_seq, r_mask,
                                             w_sample, r_shift[c_PAY_W-1:4]};
                            // Sequence advances on drops too so the
                            // receiver can see the gap.
                            r_seq        <= r_seq + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot and statistics.
    // ------------------------------------------------------------------
    always_ff @(posedge sample_clk or negedge sample_rst_n) begin
        if (!sample_rst_n) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            if (r_pend_valid) begin
                if (!(&frame_cnt)) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                if (w_load_ok) begin
                    frame_data  <= r_pend_data;
                    frame_valid <= 1'b1;
                end else if (!(&drop_cnt)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            // A drop on the same edge as en=0 still raises the flag.
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (!en) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_frame_packer
// Description : Self-checking bench for cmp_frame_packer. Counters are
//               narrowed to 4 bits so saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_frame_packer;

    localparam int c_CNT_W   = 4;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    logic               sample_clk = 1'b0;
    logic               sample_rst_n;
    logic               en;
    logic [3:0]         ch_mask;
    logic [3:0]         cmp_data;
    logic [79:0]        frame_data;
    logic               frame_valid;
    logic               frame_ready;
    logic [c_CNT_W-1:0] frame_cnt;
    logic [c_CNT_W-1:0] drop_cnt;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    cmp_frame_packer #(
        .SYNC_BYTE (8'hBC),
        .SAMPLES   (16),
        .CNT_W     (c_CNT_W)
    ) u_dut (
        .sample_clk   (sample_clk),
        .sample_rst_n (sample_rst_n),
        .en           (en),
        .ch_mask      (ch_mask),
        .cmp_data     (cmp_data),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow)
    );

    always #5 sample_clk = ~sample_clk;

    // ---------------- reference model (frame-level view) ----------------
    bit          m_fill;
    int          m_n;
    logic [3:0]  m_buf [16];
    logic [3:0]  m_mask;
    bit          m_pend;
    logic [79:0] m_pf;
    bit          m_valid;
    logic [79:0] m_data;
    logic [3:0]  m_seq;
    int          m_fcnt;
    int          m_dcnt;
    bit          m_ovf;

    function automatic int sat(input int v);
        return (v > c_CNT_MAX) ? c_CNT_MAX : v;
    endfunction

    task automatic model_reset();
        m_fill = 0; m_n = 0; m_mask = '0; m_pend = 0; m_pf = '0;
        m_valid = 0; m_data = '0; m_seq = '0; m_fcnt = 0; m_dcnt = 0; m_ovf = 0;
        for (int i = 0; i < 16; i++) m_buf[i] = '0;
    endtask

    // One clock edge, given the inputs that were stable before it.
    task automatic model_step(input logic e, input logic [3:0] mk,
                              input logic [3:0] cd, input logic rdy);
        bit          n_pend;
        logic [79:0] n_pf;
        logic [63:0] pay;
        bit          dropped;
        n_pend  = 0;
        n_pf    = m_pf;
        dropped = 0;
        // a frame completed last cycle meets the output slot now
        if (m_pend) begin
            m_fcnt = sat(m_fcnt + 1);
            if (!m_valid || rdy) begin
                m_data  = m_pf;
                m_valid = 1;
            end else begin
                m_dcnt  = sat(m_dcnt + 1);
                dropped = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (dropped) m_ovf = 1;
        else if (!e) m_ovf = 0;
        // sample collection
        if (!e) begin
            m_fill = 0;
            m_n    = 0;
        end else if (!m_fill) begin
            m_fill = 1;
        end else begin
            if (m_n == 0) m_mask = mk;
            m_buf[m_n] = cd & m_mask;
            m_n++;
            if (m_n == 16) begin
                pay = '0;
                for (int k = 0; k < 16; k++)
                    for (int c = 0; c < 4; c++)
                        pay[4*k+c] = m_buf[k][c];
                n_pend = 1;
                n_pf   = {8'hBC, m_seq, m_mask, pay};
                m_seq  = m_seq + 4'd1;
                m_n    = 0;
            end
        end
        m_pend = n_pend;
        m_pf   = n_pf;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("frame_valid", 80'(frame_valid), 80'(m_valid));
        check("frame_data",  frame_data, m_data);
        check("frame_cnt",   80'(frame_cnt), 80'(m_fcnt));
        check("drop_cnt",    80'(drop_cnt), 80'(m_dcnt));
        check("overflow",    80'(overflow), 80'(m_ovf));
    endtask

    task automatic step();
        @(posedge sample_clk);
        model_step(en, ch_mask, cmp_data, frame_ready);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        en = 0; ch_mask = '0; cmp_data = '0; frame_ready = 0;
        sample_rst_n = 0;
        #3;
        model_reset();
        compare_all();
        @(negedge sample_clk);
        sample_rst_n = 1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  data;
        logic [79:0] exp;
    } vec_t;

    vec_t        vecs [5];
    logic [79:0] held;
    int          waited;

    initial begin
        vecs[0] = '{4'hF, 4'hA, {8'hBC, 4'h0, 4'hF, 64'hAAAA_AAAA_AAAA_AAAA}};
        vecs[1] = '{4'h5, 4'hF, {8'hBC, 4'h0, 4'h5, 64'h5555_5555_5555_5555}};
        vecs[2] = '{4'h3, 4'h6, {8'hBC, 4'h0, 4'h3, 64'h2222_2222_2222_2222}};
        vecs[3] = '{4'h0, 4'hF, {8'hBC, 4'h0, 4'h0, 64'h0}};
        vecs[4] = '{4'h8, 4'h9, {8'hBC, 4'h0, 4'h8, 64'h8888_8888_8888_8888}};

        sample_rst_n = 0;
        do_reset();
        check("reset_valid", 80'(frame_valid), 80'd0);
        check("reset_data",  frame_data, 80'd0);

        // Single frames with constant data: first edge moves to FILL,
        // 16 capture edges, then one edge to load the slot.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            en = 1; ch_mask = vecs[v].mask; cmp_data = vecs[v].data; frame_ready = 1;
            for (int i = 1; i <= 18; i++) begin
                step();
                if (i == 17) check("tv_valid_early", 80'(frame_valid), 80'd0);
            end
            check("tv_valid", 80'(frame_valid), 80'd1);
            check("tv_data",  frame_data, vecs[v].exp);
        end

        // Mid-frame mask change only affects the following frame.
        do_reset();
        en = 1; ch_mask = 4'h5; cmp_data = 4'hF; frame_ready = 1;
        run(8);
        ch_mask = 4'h0;
        run(10);
        check("mask_f0", frame_data, {8'hBC, 4'h0, 4'h5, 64'h5555_5555_5555_5555});
        run(16);
        check("mask_f1_valid", 80'(frame_valid), 80'd1);
        check("mask_f1", frame_data, {8'hBC, 4'h1, 4'h0, 64'h0});

        // Stall: frame 0 held, frame 1 dropped, next emitted carries seq 2.
        do_reset();
        en = 1; ch_mask = 4'hF; frame_ready = 0;
        for (int i = 0; i < 18; i++) begin cmp_data = 4'($urandom); step(); end
        held = frame_data;
        for (int i = 0; i < 20; i++) begin
            cmp_data = 4'($urandom);
            step();
            check("hold_stable", frame_data, held);
        end
        check("stall_drop", 80'(drop_cnt), 80'd1);
        check("stall_ovf",  80'(overflow), 80'd1);
        frame_ready = 1;
        waited = 0;
        do begin cmp_data = 4'($urandom); step(); waited++; end
        while (!(frame_valid && frame_data !== held) && waited < 40);
        check("stall_seq", 80'(frame_data[71:68]), 80'd2);

        // Abort at index 9; the restarted frame is all fresh samples.
        run(9);
        en = 0;
        step();
        check("abort_ovf", 80'(overflow), 80'd0);
        en = 1;
        waited = 0;
        frame_ready = 1;
        step();
        do begin cmp_data = 4'($urandom); step(); waited++; end
        while (!frame_valid && waited < 40);
        check("abort_latency", 80'(waited), 80'd17);
        check("abort_seq", 80'(frame_data[71:68]), 80'd3);

        // Ready on the completion load edge: back-to-back, no drop.
        do_reset();
        en = 1; ch_mask = 4'hF; cmp_data = 4'h3; frame_ready = 0;
        run(33);
        frame_ready = 1;
        step();
        frame_ready = 0;
        check("b2b_valid", 80'(frame_valid), 80'd1);
        check("b2b_seq",   80'(frame_data[71:68]), 80'd1);
        check("b2b_drop",  80'(drop_cnt), 80'd0);

        // Asynchronous reset mid-fill with a pending output frame.
        do_reset();
        en = 1; ch_mask = 4'hF; cmp_data = 4'hC; frame_ready = 0;
        run(23);
        check("pre_rst_valid", 80'(frame_valid), 80'd1);
        #2;
        sample_rst_n = 0;
        #1;
        check("arst_valid", 80'(frame_valid), 80'd0);
        check("arst_data",  frame_data, 80'd0);
        check("arst_fcnt",  80'(frame_cnt), 80'd0);
        check("arst_ovf",   80'(overflow), 80'd0);
        model_reset();
        en = 0;
        @(negedge sample_clk);
        sample_rst_n = 1;

        // Saturation: 20 frames complete, 19 dropped, 4-bit counters.
        en = 1; frame_ready = 0;
        for (int i = 0; i < 330; i++) begin
            ch_mask = 4'($urandom); cmp_data = 4'($urandom); step();
        end
        check("sat_fcnt", 80'(frame_cnt), 80'(c_CNT_MAX));
        check("sat_dcnt", 80'(drop_cnt), 80'(c_CNT_MAX));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 60) != 0);
            frame_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom);
            cmp_data    = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
